// File: rtl/btn_event_fsm_if.sv
// btn_event_fsm_if: debounced level in, classified button events out.
// master drives the level; slave is the event classifier.
interface btn_event_fsm_if #(
  parameter int CNT_W = 8
);
  logic             db_in;
  logic             press_tick;
  logic             release_tick;
  logic             single_tick;
  logic             double_tick;
  logic             long_tick;
  logic [CNT_W-1:0] press_count;

  modport master (
    output db_in,
    input  press_tick,
    input  release_tick,
    input  single_tick,
    input  double_tick,
    input  long_tick,
    input  press_count
  );

  modport slave (
    input  db_in,
    output press_tick,
    output release_tick,
    output single_tick,
    output double_tick,
    output long_tick,
    output press_count
  );
endinterface

// File: rtl/btn_event_fsm.sv
// btn_event_fsm: turns a debounced level into press/release/click/long pulses.
// Define DBL_CLICK_EN to add double-click detection (GAP/PRESSED2 states).
module btn_event_fsm #(
  parameter int TICK_DIV = 50000,
  parameter int LONG_MS  = 1000,
  parameter int DBL_MS   = 300,
  parameter int CNT_W    = 8
) (
  input  logic             clk_amisha,
  input  logic             reset_n_amisha,
  input  logic             db_in,
  output logic             press_tick,
  output logic             release_tick,
  output logic             single_tick,
  output logic             double_tick,
  output logic             long_tick,
  output logic [CNT_W-1:0] press_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] LONG_TH = 16'(LONG_MS - 1);
`ifdef DBL_CLICK_EN
  localparam logic [15:0] DBL_TH = 16'(DBL_MS - 1);
`endif

  if (TICK_DIV < 2 || LONG_MS < 1 || LONG_MS > 65535 ||
      DBL_MS < 1 || DBL_MS > 65535 || CNT_W < 1) begin : g_bad_param
    $error("btn_event_fsm: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    LONG     = 3'd2
`ifdef DBL_CLICK_EN
    ,
    GAP      = 3'd3,
    PRESSED2 = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic             db_prev_q;
  logic [15:0]      timer_q, timer_d;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             sgl_q, sgl_d;
  logic             dbl_q, dbl_d;
  logic             long_q, long_d;

  logic rise, fall, ms_tick;

  assign rise    = db_in & ~db_prev_q;
  assign fall    = ~db_in & db_prev_q;
  assign ms_tick = (presc_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    sgl_d   = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        // release wins over a long threshold hit in the same cycle
        if (fall) begin
          rel_d = 1'b1;
`ifdef DBL_CLICK_EN
          state_d = GAP;
`else
          state_d = IDLE;
          sgl_d   = 1'b1;
`endif
        end else if (ms_tick && timer_q == LONG_TH) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end
      end
`ifdef DBL_CLICK_EN
      GAP: begin
        if (rise) begin
          state_d = PRESSED2;
          press_d = 1'b1;
          dbl_d   = 1'b1;
        end else if (ms_tick && timer_q == DBL_TH) begin
          state_d = IDLE;
          sgl_d   = 1'b1;
        end
      end
      PRESSED2: begin
        if (fall) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    cnt_d = press_d ? cnt_q + CNT_W'(1) : cnt_q;

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (ms_tick && timer_q != 16'hFFFF) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_q   <= IDLE;
      db_prev_q <= 1'b0;
      timer_q   <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      sgl_q     <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_prev_q <= db_in;
      timer_q   <= timer_d;
      presc_q   <= ms_tick ? '0 : presc_q + PW'(1);
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      sgl_q     <= sgl_d;
      dbl_q     <= dbl_d;
      long_q    <= long_d;
    end
  end

  assign press_tick   = press_q;
  assign release_tick = rel_q;
  assign single_tick  = sgl_q;
  assign double_tick  = dbl_q;
  assign long_tick    = long_q;
  assign press_count  = cnt_q;

endmodule
